// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the Venus data-memory responder.
// Holds the bus widths, the I/O window base, the I/O register offsets,
// STATUS bit positions and the STATUS register layout.
package dmem_responder_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned TX_W           = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    localparam logic [ADDR_W-1:0] IO_BASE = 16'hFF00;

    // I/O register offsets from IO_BASE
    localparam logic [7:0] IO_TXDATA = 8'd0;
    localparam logic [7:0] IO_STATUS = 8'd1;
    localparam logic [7:0] IO_CYCLE  = 8'd2;
    localparam logic [7:0] IO_HALT   = 8'd3;

    // Write-data bit that clears STATUS.overflow, and the HALT set bit
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned HALT_SET_BIT = 0;

    // STATUS read layout: bit0 full, bit1 empty, bit2 overflow, bits[7:4] count
    typedef struct packed {
        logic [23:0] rsvd_hi;
        logic [3:0]  count;
        logic        rsvd_lo;
        logic        overflow;
        logic        empty;
        logic        full;
    } status_t;

    function automatic logic [ADDR_W-1:0] io_addr(input logic [7:0] off);
        return IO_BASE + ADDR_W'(off);
    endfunction

endpackage

// File: rtl/dmem32x64k.sv
// 64K x 32 synchronous data SRAM with one-cycle read latency.
// Ports: clk; A address; W write enable; D write data; Q read data of the
// address sampled on the previous edge (old data on read-during-write).
module dmem32x64k
    import dmem_responder_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] A,
    input  logic              W,
    input  logic [WORD_W-1:0] D,
    output logic [WORD_W-1:0] Q
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (W) begin
            mem[A] <= D;
        end
        Q <= mem[A];
    end

endmodule

// File: rtl/dmem_responder_tx_fifo.sv
// Parameterised synchronous FIFO (power-of-two depth) for the TX byte path.
// Ports: clk, rst (sync, active-high); push/wdata enqueue; pop dequeue;
// rdata head entry (0 when empty); full, empty, count (0..DEPTH).
module dmem_responder_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves this cycle
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = (cnt == '0) ? '0 : mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the Venus core data port: SRAM below IO_BASE,
// memory-mapped TX FIFO / STATUS / CYCLE / HALT registers from IO_BASE up.
// Optional feature macro: VENUS_CYCLE_COUNTER_EN (enables the CYCLE counter).
// Ports: clk; rst (sync, active-high); A/W/D core request; Q read data one
// cycle after A; tx_data_o/tx_valid_o/tx_ready_i TX byte stream;
// halt_o sticky halt request.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic              W,
    input  logic [WORD_W-1:0] D,
    output logic [WORD_W-1:0] Q,
    output logic [TX_W-1:0]   tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              halt_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] A_TXDATA = io_addr(IO_TXDATA);
    localparam logic [ADDR_W-1:0] A_STATUS = io_addr(IO_STATUS);
    localparam logic [ADDR_W-1:0] A_CYCLE  = io_addr(IO_CYCLE);
    localparam logic [ADDR_W-1:0] A_HALT   = io_addr(IO_HALT);

    logic              io_hit;
    logic              mem_w;
    logic              wr_tx;
    logic              wr_status;
    logic              wr_halt;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] mem_q;
    logic [WORD_W-1:0] io_rdata;
    logic [WORD_W-1:0] io_q;
    logic [WORD_W-1:0] cycle_val;
    logic              sel_io_q;
    logic              rd_valid_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              halt_q;
    logic              halt_d;
    status_t           status;

    dmem32x64k u_dmem (
        .clk (clk),
        .A   (A),
        .W   (mem_w),
        .D   (D),
        .Q   (mem_q)
    );

    dmem_responder_tx_fifo #(
        .WIDTH (TX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (D[TX_W-1:0]),
        .rdata (tx_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid_o = !fifo_empty;

    // Address decode, FIFO handshake and overflow/halt next-state
    always_comb begin
        io_hit    = (A >= IO_BASE);
        mem_w     = W && !io_hit;
        wr_tx     = W && (A == A_TXDATA);
        wr_status = W && (A == A_STATUS);
        wr_halt   = W && (A == A_HALT);
        pop       = tx_valid_o && tx_ready_i;
        push      = wr_tx && (!fifo_full || pop);

        // Set is applied after clear so a same-cycle set wins
        ovf_d = ovf_q;
        if (wr_status && D[ST_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (wr_tx && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        halt_d = halt_q || (wr_halt && D[HALT_SET_BIT]);
    end

    // I/O read mux, built from state before this edge's updates
    always_comb begin
        status          = '0;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.overflow = ovf_q;
        status.count    = 4'(fifo_count);

        io_rdata = '0;
        case (A)
            A_STATUS: io_rdata = status;
            A_CYCLE:  io_rdata = cycle_val;
            A_HALT:   io_rdata = WORD_W'(halt_q);
            default:  io_rdata = '0;
        endcase
    end

`ifdef VENUS_CYCLE_COUNTER_EN
    logic [WORD_W-1:0] cycle_q;
    logic              wr_cycle;

    assign wr_cycle = W && (A == A_CYCLE);

    // Free-running counter; a write in the same cycle forces zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (wr_cycle) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + WORD_W'(1);
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // Read-path pipeline and control flops
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_io_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            io_q       <= '0;
            ovf_q      <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            sel_io_q   <= io_hit;
            rd_valid_q <= 1'b1;
            io_q       <= io_rdata;
            ovf_q      <= ovf_d;
            halt_q     <= halt_d;
        end
    end

    // Q is held at 0 until the first post-reset read, since the SRAM output is not reset
    always_comb begin
        Q = '0;
        if (rd_valid_q) begin
            Q = sel_io_q ? io_q : mem_q;
        end
    end

    assign halt_o = halt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// counter sequence and randomized traffic checked against a behavioural model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 8;
`ifdef VENUS_CYCLE_COUNTER_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A;
    logic        W;
    logic [31:0] D;
    logic [31:0] Q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .W          (W),
        .D          (D),
        .Q          (Q),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .halt_o     (halt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] mem_m [logic [15:0]];
    logic [7:0]  q_m [$];
    bit          ovf_m  = 1'b0;
    bit          halt_m = 1'b0;
    int unsigned ec     = 0;
    int unsigned base   = 0;

    typedef struct {
        bit          r;
        logic [15:0] a;
        bit          w;
        logic [31:0] d;
        bit          rdy;
        bit          cq;
        logic [31:0] q;
        bit          v;
        logic [7:0]  dt;
        bit          h;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [3:0] c;
        c = 4'(q_m.size());
        return {24'h0, c, 1'b0, ovf_m, q_m.size() == 0, q_m.size() == DEPTH};
    endfunction

    function automatic vec_t mk(bit r, logic [15:0] a, bit w, logic [31:0] d, bit rdy,
                                bit cq, logic [31:0] q, bit v, logic [7:0] dt, bit h);
        vec_t x;
        x.r = r; x.a = a; x.w = w; x.d = d; x.rdy = rdy;
        x.cq = cq; x.q = q; x.v = v; x.dt = dt; x.h = h;
        return x;
    endfunction

    // Apply one cycle of inputs, advance the model, clock, and compare
    task automatic step(input bit r, input logic [15:0] a, input bit w,
                        input logic [31:0] d, input bit rdy);
        logic [31:0] exp_q;
        logic [7:0]  hd;
        bit          known;
        rst = r; A = a; W = w; D = d; tx_ready = rdy;
        known = 1'b1;
        exp_q = 32'h0;
        if (r) begin
            q_m.delete();
            ovf_m  = 1'b0;
            halt_m = 1'b0;
            base   = ec + 1;
        end else begin
            if (a >= 16'hFF00) begin
                case (a)
                    16'hFF01: exp_q = status_m();
                    16'hFF02: exp_q = CYC_EN ? 32'(ec - base) : 32'h0;
                    16'hFF03: exp_q = {31'h0, halt_m};
                    default:  exp_q = 32'h0;
                endcase
            end else if (mem_m.exists(a)) begin
                exp_q = mem_m[a];
            end else begin
                known = 1'b0;
            end
            if (q_m.size() > 0 && rdy) begin
                void'(q_m.pop_front());
            end
            if (w) begin
                case (a)
                    16'hFF00: begin
                        if (q_m.size() < DEPTH) q_m.push_back(d[7:0]);
                        else ovf_m = 1'b1;
                    end
                    16'hFF01: if (d[2]) ovf_m = 1'b0;
                    16'hFF02: base = ec + 1;
                    16'hFF03: if (d[0]) halt_m = 1'b1;
                    default:  if (a < 16'hFF00) mem_m[a] = d;
                endcase
            end
        end
        @(posedge clk);
        #1;
        ec++;
        hd = (q_m.size() > 0) ? q_m[0] : 8'h00;
        if (known) chk("model_q", Q, exp_q);
        chk("model_tx_valid", 32'(tx_valid), 32'(q_m.size() > 0));
        chk("model_tx_data", 32'(tx_data), 32'(hd));
        chk("model_halt", 32'(halt), 32'(halt_m));
    endtask

    initial begin
        logic [15:0] pool [4];
        logic [15:0] a;
        pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h1234; pool[3] = 16'hFEFF;
        rst = 1'b1; A = 16'h0; W = 1'b0; D = 32'h0; tx_ready = 1'b0;

        // Directed table: reset, memory, FIFO fill/overflow/drain, halt, reset
        vecs.push_back(mk(1, 16'h0000, 0, 32'h0,        0, 1, 32'h0,        0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0010, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0010, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 16'hFF00, 1, 32'(8'h41 + i), 0, 1, 32'h0, 1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h81, 1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF00, 1, 32'h5A, 0, 1, 32'h0,  1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h85, 1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF01, 1, 32'h4,  0, 1, 32'h85, 1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h81, 1, 8'h41, 0));
        vecs.push_back(mk(0, 16'hFF00, 1, 32'h49, 1, 1, 32'h0,  1, 8'h42, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h81, 1, 8'h42, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 16'h0010, 0, 32'h0, 1, 1, 32'hDEADBEEF,
                              i < 7, (i < 7) ? 8'(8'h43 + i) : 8'h00, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h2,        0, 8'h00, 0));
        vecs.push_back(mk(0, 16'hFF03, 1, 32'h1,  0, 1, 32'h0,        0, 8'h00, 1));
        vecs.push_back(mk(0, 16'hFF03, 0, 32'h0,  0, 1, 32'h1,        0, 8'h00, 1));
        vecs.push_back(mk(0, 16'hFF03, 1, 32'h0,  0, 1, 32'h1,        0, 8'h00, 1));
        vecs.push_back(mk(0, 16'hFF00, 1, 32'h11, 0, 1, 32'h0,        1, 8'h11, 1));
        vecs.push_back(mk(0, 16'hFF00, 1, 32'h22, 0, 1, 32'h0,        1, 8'h11, 1));
        vecs.push_back(mk(1, 16'h0000, 0, 32'h0,  1, 1, 32'h0,        0, 8'h00, 0));
        vecs.push_back(mk(0, 16'hFF01, 0, 32'h0,  0, 1, 32'h2,        0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0010, 0, 32'h0,  0, 1, 32'hDEADBEEF, 0, 8'h00, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].rdy);
            if (vecs[i].cq) chk($sformatf("vec%0d_q", i), Q, vecs[i].q);
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].dt));
            chk($sformatf("vec%0d_halt", i), 32'(halt), 32'(vecs[i].h));
        end

        // Cycle counter: 10 cycles after reset, then write-to-zero
        step(1, 16'h0000, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 16'h0010, 0, 32'h0, 0);
        step(0, 16'hFF02, 0, 32'h0, 0);
        chk("cycle_after_10", Q, CYC_EN ? 32'd10 : 32'd0);
        step(0, 16'hFF02, 1, 32'h12345678, 0);
        chk("cycle_at_write", Q, CYC_EN ? 32'd11 : 32'd0);
        step(0, 16'hFF02, 0, 32'h0, 0);
        chk("cycle_after_write", Q, 32'd0);
        step(0, 16'hFF02, 0, 32'h0, 0);
        chk("cycle_next", Q, CYC_EN ? 32'd1 : 32'd0);

        // Seed memory pool so random reads are predictable
        for (int i = 0; i < 4; i++) step(0, pool[i], 1, $urandom, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 5) a = pool[$urandom_range(0, 3)];
            else if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
            else a = 16'hFF00 + 16'($urandom_range(0, 5));
            step($urandom_range(0, 149) == 0, a, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
